// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the bus transfer sequencer.
package bus_xfer_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StIdle  = 3'd0,
        StDrive = 3'd1,
        StLoad  = 3'd2,
        StDone  = 3'd3,
        StErr   = 3'd4,
        StTurn  = 3'd5
    } state_e;

    // Each sequencing phase lasts exactly one clock.
    localparam int unsigned DriveCycles = 1;
    localparam int unsigned LoadCycles  = 1;
    localparam int unsigned DonePulse   = 1;
    localparam int unsigned ErrPulse    = 1;

endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; out-of-range indices decode to all zeros.
module onehot_dec #(
    parameter int unsigned NREGS = 4,
    parameter int unsigned IDXW  = $clog2(NREGS) + 1
) (
    input  logic [IDXW-1:0]  idx_i,
    input  logic             en_i,
    output logic [NREGS-1:0] vec_o
);

    // Compare against every legal index; nothing matches an out-of-range value.
    always_comb begin
        vec_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (en_i && (idx_i == IDXW'(i))) begin
                vec_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: accepts one src -> dst request and drives the register bank's
// output-enable and load strobes so a single driver owns the bus while dst captures.
// Optional feature: define BUS_TURNAROUND_EN to add a one-cycle TURN state after DONE.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int unsigned NREGS = 4,
    parameter int unsigned IDXW  = $clog2(NREGS) + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [IDXW-1:0]  req_src_i,
    input  logic [IDXW-1:0]  req_dst_i,
    input  logic             req_ext_i,
    output logic [NREGS-1:0] reg_enable_o,
    output logic             ext_enable_o,
    output logic [NREGS-1:0] reg_load_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    state_e          state_q;
    logic [IDXW-1:0] src_q;
    logic [IDXW-1:0] dst_q;
    logic            ext_q;

    logic req_illegal;
    logic drive_phase;
    logic src_en;
    logic load_en;

    assign req_illegal = (req_dst_i >= IDXW'(NREGS))
                       || (!req_ext_i && (req_src_i >= IDXW'(NREGS)))
                       || (!req_ext_i && (req_src_i == req_dst_i));

    // Sequencer: captures the request on acceptance and steps through the phases.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            ext_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        src_q   <= req_src_i;
                        dst_q   <= req_dst_i;
                        ext_q   <= req_ext_i;
                        state_q <= req_illegal ? StErr : StDrive;
                    end
                end
                StDrive: state_q <= StLoad;
                StLoad:  state_q <= StDone;
`ifdef BUS_TURNAROUND_EN
                StDone:  state_q <= StTurn;
`else
                StDone:  state_q <= StIdle;
`endif
                StErr:   state_q <= StIdle;
                StTurn:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes decode only from registered state and indices. The load strobe is also
    // masked by reset so an abandoned transfer never writes its destination.
    assign drive_phase  = (state_q == StDrive) || (state_q == StLoad);
    assign src_en       = drive_phase && !ext_q;
    assign ext_enable_o = drive_phase && ext_q;
    assign load_en      = (state_q == StLoad) && !reset_i;

    onehot_dec #(
        .NREGS (NREGS),
        .IDXW  (IDXW)
    ) u_src_dec (
        .idx_i (src_q),
        .en_i  (src_en),
        .vec_o (reg_enable_o)
    );

    onehot_dec #(
        .NREGS (NREGS),
        .IDXW  (IDXW)
    ) u_dst_dec (
        .idx_i (dst_q),
        .en_i  (load_en),
        .vec_o (reg_load_o)
    );

    assign req_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign err_o       = (state_q == StErr);

endmodule
